accel_frame_sched: RTL
======================

// Module: accel_frame_sched
// PURPOSE
//  Frame sequencer for the image accelerator. It sits between the AXI-lite register file and the stream datapath.
//  Latches the frame length on a start command and admits exactly that many input AXIS words (LOAD).
//  Then kicks the compute engine and waits for it to finish (RUN), and releases exactly that many output words (DRAIN).
//  It generates the output TLAST, reports status and errors, and pulses an interrupt at end of frame.
// PARAMETERS
//  CNT_W        16   width of frame word counters; max frame = 2**CNT_W-1 words
//  DEF_WORDS    576  frame length used when cfg_words==0 (576 words = 2304 pixels)
// PORTS
//  clk            in   1      clock; all logic rising-edge
//  rstn           in   1      reset, asynchronous, active-low
//  cfg_start      in   1      1-cycle pulse: ctrl reg write with bit0=1
//  cfg_abort      in   1      1-cycle pulse: ctrl reg write with bit1=1
//  cfg_words      in   CNT_W  frame length in 32-bit words, sampled on accepted start
//  s_axis_tvalid  in   1      input stream valid (from DMA)
//  s_axis_tlast   in   1      input stream last
//  s_axis_tready  out  1      input ready (gated by this block)
//  eng_start      out  1      1-cycle pulse to compute engine
//  eng_done       in   1      1-cycle pulse from engine: result ready
//  eng_tvalid     in   1      engine output valid
//  eng_tready     out  1      = m_axis_tready & out_en
//  m_axis_tvalid  out  1      = eng_tvalid & out_en
//  m_axis_tlast   out  1      out_en & eng_tvalid & (out_cnt==len-1)
//  m_axis_tready  in   1      output ready (from DMA)
//  busy           out  1      state != IDLE
//  done_irq       out  1      1-cycle pulse on DONE
//  err_early      out  1      sticky: s_axis_tlast before final word
//  err_nolast     out  1      sticky: final input word without tlast
//  in_cnt,out_cnt out  CNT_W  words accepted / emitted in current frame
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE; all outputs 0; len=0; counters 0; error flags 0.
//  States: IDLE -> LOAD -> RUN -> DRAIN -> DONE -> IDLE. The state register drives all gating (no comb path from inputs to ready).
//  IDLE: on cfg_start: len <= (cfg_words==0 ? DEF_WORDS : cfg_words); in_cnt,out_cnt,err_* <= 0; go LOAD.
//  LOAD: s_axis_tready=1. Each s_tvalid&s_tready increments in_cnt.
//   Word with in_cnt==len-1 -> RUN next cycle. If tlast=0 on this word, set err_nolast and still proceed.
//   tlast on word with in_cnt<len-1 -> set err_early, go IDLE (frame dropped, no irq).
//  RUN: s_axis_tready=0. eng_start=1 for exactly the first cycle in RUN. Wait for eng_done -> DRAIN.
//   eng_done in the same cycle as eng_start is legal and is honoured.
//  DRAIN: out_en=1. Each m_tvalid&m_tready increments out_cnt. Beat with out_cnt==len-1 carries tlast -> DONE.
//  DONE: done_irq=1 for one cycle; busy=0 from next cycle -> IDLE. Counters hold until next start.
//  cfg_start when not IDLE: ignored, no side effect.
//  cfg_abort in any state: next state IDLE; readies/valids drop next cycle; no irq; err flags held.
//   If abort and start arrive together in IDLE, abort wins.
//  len==1: a single word is both first and last in LOAD and DRAIN.
//  Counters never wrap; len is bounded by CNT_W.
// STRUCTURE
//  Package accel_pkg: state encoding localparams (IDLE=0,LOAD=1,RUN=2,DRAIN=3,DONE=4), CTRL bit positions (START=0, ABORT=1), DEF_WORDS.
//  Single module. One reusable sub-module, beat_counter (en, clr, len -> cnt, last), is instantiated twice (in/out).
// TESTING
//  1 start, cfg_words=576, 576 input words with tlast on #575, eng_done 10 cyc later, m_tready=1 ->
//    576 outputs with tlast only on #575; done_irq exactly 1 cycle; no errors.
//  2 cfg_words=576, tlast on word #99 -> err_early=1, in_cnt=100, state IDLE, eng_start never, no irq.
//  3 cfg_words=4, no tlast on word #3 -> err_nolast=1, RUN entered, frame completes with irq.
//  4 cfg_words=0 -> len=576; second cfg_start during LOAD ignored (in_cnt keeps counting, len unchanged).
//  5 cfg_abort at in_cnt=300 -> s_axis_tready=0 next cycle, busy=0; new start with cfg_words=1 -> 1-word frame, tlast+irq.
//  6 m_axis_tready toggling 1/0 each cycle during DRAIN; rstn pulsed low mid-DRAIN ->
//    no lost/duplicated beats before reset; all outputs 0 immediately on reset.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared definitions for the image accelerator frame sequencer.
package accel_pkg;

  localparam int ACCEL_CNT_W     = 16;
  localparam int ACCEL_DEF_WORDS = 576;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/beat_counter.sv
// Saturating beat counter with a "this is the final beat" flag.
module beat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  // Count accepted beats; clear on a new frame and stop at the top value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == (len - ONE));

endmodule

// File: rtl/accel_frame_sched.sv
// Frame sequencer: admits a frame of input words, kicks the engine,
// then releases the same number of output words with TLAST.
module accel_frame_sched
  import accel_pkg::*;
#(
  parameter int CNT_W     = ACCEL_CNT_W,
  parameter int DEF_WORDS = ACCEL_DEF_WORDS
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [CNT_W-1:0] cfg_words,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic             eng_start,
  input  logic             eng_done,
  input  logic             eng_tvalid,
  output logic             eng_tready,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             busy,
  output logic             done_irq,
  output logic             err_early,
  output logic             err_nolast,
  output logic [CNT_W-1:0] in_cnt,
  output logic [CNT_W-1:0] out_cnt
);

  localparam logic [CNT_W-1:0] DEF_LEN = CNT_W'(DEF_WORDS);

  state_t           r_state;
  logic [CNT_W-1:0] r_len;
  logic             r_eng_start;
  logic             r_err_early;
  logic             r_err_nolast;

  logic w_load;
  logic w_out_en;
  logic w_in_fire;
  logic w_out_fire;
  logic w_in_last;
  logic w_out_last;
  logic w_clr;

  // All gating is decoded from the state register only.
  assign w_load     = (r_state == ST_LOAD);
  assign w_out_en   = (r_state == ST_DRAIN);
  assign w_in_fire  = s_axis_tvalid & w_load;
  assign w_out_fire = eng_tvalid & m_axis_tready & w_out_en;
  assign w_clr      = (r_state == ST_IDLE) & cfg_start & ~cfg_abort;

  beat_counter #(.CNT_W(CNT_W)) u_in_cnt (
    .clk  (clk),
    .rstn (rstn),
    .en   (w_in_fire),
    .clr  (w_clr),
    .len  (r_len),
    .cnt  (in_cnt),
    .last (w_in_last)
  );

  beat_counter #(.CNT_W(CNT_W)) u_out_cnt (
    .clk  (clk),
    .rstn (rstn),
    .en   (w_out_fire),
    .clr  (w_clr),
    .len  (r_len),
    .cnt  (out_cnt),
    .last (w_out_last)
  );

  // Frame sequencing FSM; abort overrides everything, including a start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_eng_start  <= 1'b0;
      r_err_early  <= 1'b0;
      r_err_nolast <= 1'b0;
    end else begin
      r_eng_start <= 1'b0;
      if (cfg_abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (cfg_start) begin
              r_len        <= (cfg_words == '0) ? DEF_LEN : cfg_words;
              r_err_early  <= 1'b0;
              r_err_nolast <= 1'b0;
              r_state      <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (w_in_fire) begin
              if (w_in_last) begin
                if (!s_axis_tlast) begin
                  r_err_nolast <= 1'b1;
                end
                r_eng_start <= 1'b1;
                r_state     <= ST_RUN;
              end else if (s_axis_tlast) begin
                r_err_early <= 1'b1;
                r_state     <= ST_IDLE;
              end
            end
          end
          ST_RUN: begin
            if (eng_done) begin
              r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (w_out_fire && w_out_last) begin
              r_state <= ST_DONE;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign s_axis_tready = w_load;
  assign eng_start     = r_eng_start;
  assign eng_tready    = m_axis_tready & w_out_en;
  assign m_axis_tvalid = eng_tvalid & w_out_en;
  assign m_axis_tlast  = w_out_en & eng_tvalid & w_out_last;
  assign busy          = (r_state != ST_IDLE);
  assign done_irq      = (r_state == ST_DONE);
  assign err_early     = r_err_early;
  assign err_nolast    = r_err_nolast;

endmodule
